// File: rtl/gerencia_matriz_param.sv
// gerencia_matriz_param: loads matrices A/B from RAM, writes ALU result back; GM_CLEAR_ON_START_EN zeroes A/B on a load start
module gerencia_matriz_param #(
  parameter int W = 9,
  parameter int DIM = 5,
  parameter int ADDR_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [1:0]              mode,
  input  logic [ADDR_W-1:0]       base_a,
  input  logic [ADDR_W-1:0]       base_b,
  input  logic [ADDR_W-1:0]       base_r,
  input  logic [W*DIM*DIM-1:0]    matriz_resultante,
  input  logic                    res_valid,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [W-1:0]            mem_wdata,
  output logic                    mem_we,
  input  logic [W-1:0]            mem_rdata,
  output logic [W*DIM*DIM-1:0]    matriz1,
  output logic [W*DIM*DIM-1:0]    matriz2,
  output logic                    load_done,
  output logic                    busy,
  output logic                    done
);
  localparam int E = DIM * DIM;
  localparam int CW = $clog2(2 * E + RD_LAT + 1);
  typedef enum logic [2:0] {IDLE, LOAD, WAIT_RES, STORE, DONE} state_t;
  state_t state;
  logic [1:0] mode_q;
  logic [ADDR_W-1:0] ba, bb, br;
  logic [CW-1:0] cnt, nxt, cap;
  logic [ADDR_W-1:0] nxt_addr;
  logic [W*E-1:0] res;
  assign nxt = cnt + CW'(1);
  assign cap = cnt - CW'(RD_LAT);
  assign nxt_addr = (nxt < CW'(E)) ? ba + ADDR_W'(nxt) : bb + ADDR_W'(nxt - CW'(E));
  // cnt indexes issued reads; the word issued RD_LAT cycles ago is captured at index cap
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      mode_q <= '0;
      ba <= '0;
      bb <= '0;
      br <= '0;
      cnt <= '0;
      res <= '0;
      mem_addr <= '0;
      mem_wdata <= '0;
      mem_we <= 1'b0;
      matriz1 <= '0;
      matriz2 <= '0;
      load_done <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      load_done <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: if (start && !done) begin
          mode_q <= mode;
          ba <= base_a;
          bb <= base_b;
          br <= base_r;
          cnt <= '0;
          busy <= 1'b1;
          state <= (mode == 2'b01) ? WAIT_RES : LOAD;
          if (mode != 2'b01) begin
            mem_addr <= base_a;
`ifdef GM_CLEAR_ON_START_EN
            matriz1 <= '0;
            matriz2 <= '0;
`endif
          end
        end
        LOAD: begin
          cnt <= nxt;
          mem_addr <= (nxt < CW'(2 * E)) ? nxt_addr : '0;
          if (cnt >= CW'(RD_LAT)) begin
            if (cap < CW'(E)) matriz1[cap*W +: W] <= mem_rdata;
            else matriz2[(cap - CW'(E))*W +: W] <= mem_rdata;
          end
          if (cnt == CW'(2 * E + RD_LAT - 1)) begin
            load_done <= 1'b1;
            state <= (mode_q == 2'b10) ? WAIT_RES : DONE;
          end
        end
        WAIT_RES: if (res_valid) begin
          res <= matriz_resultante;
          cnt <= '0;
          mem_we <= 1'b1;
          mem_addr <= br;
          mem_wdata <= matriz_resultante[W-1:0];
          state <= STORE;
        end
        STORE: begin
          if (cnt == CW'(E - 1)) begin
            mem_we <= 1'b0;
            mem_addr <= '0;
            mem_wdata <= '0;
            state <= DONE;
          end else begin
            cnt <= nxt;
            mem_addr <= br + ADDR_W'(nxt);
            mem_wdata <= res[nxt*W +: W];
          end
        end
        DONE: begin
          done <= 1'b1;
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_gerencia_matriz_param.sv
// tb_gerencia_matriz_param: directed vectors for load/store/wrap/latency/reset on RD_LAT=1 and RD_LAT=3 instances
module tb_gerencia_matriz_param;
  localparam int W = 9;
  localparam int E = 25;
  localparam int BW = W * E;
  typedef struct {
    logic [1:0] mode;
    logic [7:0] ba;
    logic [7:0] bb;
    int lat1;
    int lat3;
    logic [8:0] a0;
    logic [8:0] a24;
    logic [8:0] b0;
    logic [8:0] b24;
    logic zero;
    logic poke;
  } lvec_t;
  logic clk, reset, start, res_valid;
  logic [1:0] mode;
  logic [7:0] base_a, base_b, base_r;
  logic [BW-1:0] result;
  logic [7:0] addr1, addr3;
  logic [8:0] wdata1, wdata3, rdata1, rdata3, p0, p1;
  logic we1, we3, ld1, ld3, busy1, busy3, done1, done3;
  logic [BW-1:0] m1a, m2a, m1b, m2b, prev1, prev2;
  logic [8:0] ram1 [256];
  logic [8:0] ram3 [256];
  logic do_fill, fill_zero;
  int checks = 0;
  int errors = 0;
  lvec_t vt [4];

  gerencia_matriz_param #(.W(9), .DIM(5), .ADDR_W(8), .RD_LAT(1)) dut1 (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .base_a(base_a), .base_b(base_b),
    .base_r(base_r), .matriz_resultante(result), .res_valid(res_valid), .mem_addr(addr1),
    .mem_wdata(wdata1), .mem_we(we1), .mem_rdata(rdata1), .matriz1(m1a), .matriz2(m2a),
    .load_done(ld1), .busy(busy1), .done(done1));

  gerencia_matriz_param #(.W(9), .DIM(5), .ADDR_W(8), .RD_LAT(3)) dut3 (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .base_a(base_a), .base_b(base_b),
    .base_r(base_r), .matriz_resultante(result), .res_valid(res_valid), .mem_addr(addr3),
    .mem_wdata(wdata3), .mem_we(we3), .mem_rdata(rdata3), .matriz1(m1b), .matriz2(m2b),
    .load_done(ld3), .busy(busy3), .done(done3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (do_fill) begin
      for (int a = 0; a < 256; a++) begin
        ram1[a] <= fill_zero ? 9'd0 : 9'(a);
        ram3[a] <= fill_zero ? 9'd0 : 9'(a);
      end
    end else begin
      if (we1) ram1[addr1] <= wdata1;
      if (we3) ram3[addr3] <= wdata3;
    end
    rdata1 <= ram1[addr1];
    p0 <= ram3[addr3];
    p1 <= p0;
    rdata3 <= p1;
  end

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [BW-1:0] mk(input logic [7:0] b, input logic z);
    logic [BW-1:0] r;
    logic [7:0] t;
    r = '0;
    for (int i = 0; i < E; i++) begin
      t = b + 8'(i);
      r[i*W +: W] = z ? 9'd0 : {1'b0, t};
    end
    return r;
  endfunction

  task automatic fill(input logic z);
    @(negedge clk);
    fill_zero = z;
    do_fill = 1'b1;
    @(negedge clk);
    do_fill = 1'b0;
  endtask

  task automatic go(input logic [1:0] md, input logic [7:0] a, input logic [7:0] b, input logic [7:0] r);
    mode = md;
    base_a = a;
    base_b = b;
    base_r = r;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_ld();
    logic ok;
    ok = 1'b0;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(posedge clk);
      #1 ok = ld1;
    end
    check("load_done_seen", ok, 1'b1);
  endtask

  task automatic run_load(input lvec_t v);
    logic [BW-1:0] e1, e2;
    logic [7:0] ea;
    int bad, l1, l3, d1, ldcnt;
    fill(v.zero);
    go(v.mode, v.ba, v.bb, 8'd0);
    e1 = mk(v.ba, v.zero);
    e2 = mk(v.bb, v.zero);
`ifdef GM_CLEAR_ON_START_EN
    check("clear_m1_at_start", m1a, '0);
    check("clear_m2_at_start", m2a, '0);
`else
    check("hold_m1_at_start", m1a, prev1);
    check("hold_m2_at_start", m2a, prev2);
`endif
    bad = 0; l1 = -1; l3 = -1; d1 = -1; ldcnt = 0;
    for (int k = 0; k <= 60; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      if (v.poke && k == 10) begin
        start = 1'b1;
        mode = 2'b01;
        base_a = 8'h77;
      end
      if (v.poke && k == 11) start = 1'b0;
      if (k < 50) begin
        ea = (k < 25) ? v.ba + 8'(k) : v.bb + 8'(k - 25);
        if (addr1 !== ea) bad++;
      end
      if (ld1) begin
        ldcnt++;
        if (l1 < 0) l1 = k;
      end
      if (ld3 && l3 < 0) l3 = k;
      if (done1 && d1 < 0) d1 = k;
    end
    check("addr_seq_bad", bad, 0);
    check("load_done_lat_rl1", l1, v.lat1);
    check("load_done_lat_rl3", l3, v.lat3);
    check("done_lat", d1, v.lat1 + 1);
    check("load_done_width", ldcnt, 1);
    check("matriz1_rl1", m1a, e1);
    check("matriz2_rl1", m2a, e2);
    check("matriz1_rl3", m1b, e1);
    check("matriz2_rl3", m2b, e2);
    check("a0", m1a[8:0], v.a0);
    check("a24", m1a[BW-1 -: 9], v.a24);
    check("b0", m2a[8:0], v.b0);
    check("b24", m2a[BW-1 -: 9], v.b24);
    check("idle_after", busy1, 1'b0);
    prev1 = e1;
    prev2 = e2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    logic seen;
    vt[0] = '{2'b00, 8'h00, 8'd25, 51, 53, 9'd0, 9'd24, 9'd25, 9'd49, 1'b0, 1'b0};
    vt[1] = '{2'b11, 8'hF0, 8'h80, 51, 53, 9'hF0, 9'h08, 9'h80, 9'h98, 1'b0, 1'b1};
    vt[2] = '{2'b00, 8'h10, 8'hFA, 51, 53, 9'h10, 9'h28, 9'hFA, 9'h12, 1'b0, 1'b0};
    vt[3] = '{2'b00, 8'h00, 8'd25, 51, 53, 9'd0, 9'd0, 9'd0, 9'd0, 1'b1, 1'b0};
    reset = 1'b1; start = 1'b0; res_valid = 1'b0; mode = 2'b00;
    base_a = '0; base_b = '0; base_r = '0; result = '0;
    do_fill = 1'b0; fill_zero = 1'b0;
    prev1 = '0; prev2 = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy1, 1'b0);
    check("rst_we", we1, 1'b0);
    check("rst_addr", addr1, 8'd0);
    check("rst_wdata", wdata1, 9'd0);
    check("rst_flags", {ld1, done1}, 2'b00);
    check("rst_m1", m1a, '0);
    check("rst_m2", m2a, '0);
    reset = 1'b0;
    for (int v = 0; v < 4; v++) run_load(vt[v]);
    // mode 10: result arrives 10 cycles after load_done and is written back
    fill(1'b0);
    go(2'b10, 8'h00, 8'd25, 8'd100);
    wait_ld();
    prev1 = mk(8'h00, 1'b0);
    prev2 = mk(8'd25, 1'b0);
    repeat (9) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < E; i++) result[i*W +: W] = 9'h1FF - 9'(i);
    res_valid = 1'b1;
    @(posedge clk);
    #1 res_valid = 1'b0;
    result = '1;
    for (int i = 0; i < E; i++) begin
      check("store_we", we1, 1'b1);
      check("store_addr", addr1, 8'd100 + 8'(i));
      check("store_wdata", wdata1, 9'h1FF - 9'(i));
      @(posedge clk);
      #1;
    end
    check("post_store_we", we1, 1'b0);
    check("post_store_wdata", wdata1, 9'd0);
    check("done_state_busy", {busy1, done1}, 2'b10);
    @(posedge clk);
    #1 check("done_pulse", {busy1, done1}, 2'b01);
    check("ram_100", ram1[100], 9'h1FF);
    check("ram_124", ram1[124], 9'h1E7);
    check("load_then_store_m1", m1a, prev1);
    // mode 01 with res_valid already high when WAIT_RES is entered
    repeat (3) @(negedge clk);
    for (int i = 0; i < E; i++) result[i*W +: W] = 9'(i + 3);
    res_valid = 1'b1;
    go(2'b01, 8'h00, 8'h00, 8'd200);
    check("m01_wait_busy", busy1, 1'b1);
    check("m01_wait_we", we1, 1'b0);
    @(posedge clk);
    #1 check("m01_first_we", we1, 1'b1);
    check("m01_first_addr", addr1, 8'd200);
    check("m01_first_wdata", wdata1, 9'd3);
    res_valid = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(posedge clk);
      #1 seen = done1;
    end
    check("m01_done_seen", seen, 1'b1);
    check("m01_no_load", m1a, prev1);
    // reset in the middle of STORE
    repeat (3) @(negedge clk);
    go(2'b10, 8'h00, 8'd25, 8'd100);
    wait_ld();
    @(negedge clk);
    result = mk(8'h40, 1'b0);
    res_valid = 1'b1;
    @(posedge clk);
    #1 res_valid = 1'b0;
    for (int i = 0; i < 7; i++) begin
      check("pre_reset_we", we1, 1'b1);
      @(posedge clk);
      #1;
    end
    #2 reset = 1'b1;
    #1 check("reset_we_drop", {we1, we3}, 2'b00);
    check("reset_busy", {busy1, busy3}, 2'b00);
    check("reset_addr", addr1, 8'd0);
    check("reset_m1", m1a, '0);
    @(negedge clk);
    reset = 1'b0;
    prev1 = '0;
    prev2 = '0;
    run_load(vt[0]);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
